fixed_weight_enum: RTL and testbench

Sequential generator that enumerates, in ascending numeric order, every 16-bit word whose population count equals a requested weight k (0..16). It is the inverse of the team's 16-bit bit-count datapath: that block maps a word to its weight, and this block maps a weight to all C(16,k) words carrying it. Words leave on a valid/ready stream. The block feeds test-vector generation and exhaustive checking of the bit-count path.

---
 rtl/fixed_weight_enum_pkg.sv | 29 ++
 rtl/fixed_weight_enum_if.sv | 27 ++
 rtl/fixed_weight_enum_next.sv | 34 +++
 rtl/fixed_weight_enum.sv | 96 +++++++++
 tb/tb_fixed_weight_enum.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_weight_enum_pkg.sv
// Shared widths, FSM state type and sequence endpoint helpers for the
// fixed-weight word enumerator.
package fixed_weight_enum_pkg;

  localparam int WORD_W   = 16;
  localparam int WEIGHT_W = 5;
  localparam int INDEX_W  = 14;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } state_t;

  // Smallest word of weight k: the k low bits set.
  function automatic logic [WORD_W-1:0] first_word(input logic [WEIGHT_W-1:0] k);
    logic [WORD_W:0] ones;
    ones = (17'd1 << k) - 17'd1;
    return ones[WORD_W-1:0];
  endfunction

  // Largest word of weight k: the k high bits set.
  function automatic logic [WORD_W-1:0] last_word(input logic [WEIGHT_W-1:0] k);
    logic [WORD_W:0] w;
    w = {1'b0, first_word(k)} << (5'd16 - k);
    return w[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/fixed_weight_enum_if.sv
// Control and output-stream bundle between the enumerator and its consumer.
interface fixed_weight_enum_if;
  import fixed_weight_enum_pkg::*;

  logic                start;
  logic [WEIGHT_W-1:0] weight;
  logic                abort;
  logic [WORD_W-1:0]   out_word;
  logic [INDEX_W-1:0]  out_index;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    input  start, weight, abort, out_ready,
    output out_word, out_index, out_last, out_valid, busy, done, err
  );

  modport slave (
    output start, weight, abort, out_ready,
    input  out_word, out_index, out_last, out_valid, busy, done, err
  );

endinterface

// File: rtl/fixed_weight_enum_next.sv
// Combinational successor: next larger word with the same popcount
// (Gosper's step), evaluated in 17 bits so the ripple add cannot wrap.
module fixed_weight_next
  import fixed_weight_enum_pkg::*;
(
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] next_o
);

  logic [WORD_W:0]   x_ext;
  logic [WORD_W:0]   c;
  logic [WORD_W:0]   r;
  logic [WORD_W-1:0] shifted;
  logic [4:0]        ctz;

  assign x_ext = {1'b0, x_i};
  assign c     = x_ext & (~x_ext + 17'd1);
  assign r     = x_ext + c;

  // Lowest set bit of x is also the only set bit of c; scanning downward
  // lets the least significant hit win.
  always_comb begin
    ctz = '0;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      if (x_i[i]) begin
        ctz = 5'(i);
      end
    end
  end

  assign shifted = {1'b0, r[WORD_W:2] ^ x_ext[WORD_W:2]} >> ctz;
  assign next_o  = shifted | r[WORD_W-1:0];

endmodule

// File: rtl/fixed_weight_enum.sv
// Streams every 16-bit word of a requested popcount in ascending order over
// a valid/ready handshake; FSM, output registers and index counter live here.
module fixed_weight_enum
  import fixed_weight_enum_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  fixed_weight_enum_if.master bus
);

  state_t              state_q, state_d;
  logic [W-1:0]        word_q, word_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic                last_q, last_d;
  logic [WEIGHT_W-1:0] k_q, k_d;
  logic                err_q, err_d;
  logic [W-1:0]        next_word;

  fixed_weight_next u_next (
    .x_i    (word_q),
    .next_o (next_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      index_q <= index_d;
      last_q  <= last_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    index_d = index_q;
    last_d  = last_q;
    k_d     = k_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.weight <= WEIGHT_W'(W)) begin
            word_d  = first_word(bus.weight);
            index_d = '0;
            last_d  = (bus.weight == '0) || (bus.weight == WEIGHT_W'(W));
            k_d     = bus.weight;
            state_d = STREAM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        // Abort wins over a handshake in the same cycle.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.out_ready) begin
          if (last_q) begin
            state_d = FINISH;
          end else begin
            word_d  = next_word;
            index_d = index_q + 1'b1;
            last_d  = (next_word == last_word(k_q));
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out_word  = word_q;
  assign bus.out_index = index_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = (state_q == STREAM);
  assign bus.busy      = (state_q == STREAM);
  assign bus.done      = (state_q == FINISH);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_fixed_weight_enum.sv
// Scoreboard bench: expected words come from a brute-force popcount scan of
// all 16-bit values; a negedge monitor pops and compares on each handshake.
module tb_fixed_weight_enum;
  import fixed_weight_enum_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fixed_weight_enum_if bus ();

  fixed_weight_enum #(.W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] word;
    int          index;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  int          cur_k = 0;
  bit          ready_rand = 1'b0;
  bit          done_exp = 1'b0;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_word;
  logic [13:0] prev_index;
  logic [15:0] last_hs_word;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic int binom(input int k);
    longint r = 1;
    for (int i = 0; i < k; i++) r = r * (16 - i) / (i + 1);
    return int'(r);
  endfunction

  task automatic push_model(input int k);
    int n = 0;
    int idx = 0;
    exp_t e;
    for (int v = 0; v < 65536; v++) if ($countones(v[15:0]) == k) n++;
    for (int v = 0; v < 65536; v++) begin
      if ($countones(v[15:0]) == k) begin
        e.word  = v[15:0];
        e.index = idx;
        e.last  = (idx == n - 1);
        exp_q.push_back(e);
        idx++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input int k);
    tick();
    bus.weight = 5'(k);
    bus.start  = 1'b1;
    push_model(k);
    cur_k    = k;
    hs_count = 0;
    tick();
    bus.start = 1'b0;
    check("first_valid", bus.out_valid, 1);
    check("first_index", bus.out_index, 0);
    $display("start k=%0d first_word=0x%04h last=%0b", k, bus.out_word, bus.out_last);
  endtask

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", bus.done, 1);
    check("word_count", hs_count, binom(k));
    check("queue_empty", exp_q.size(), 0);
    $display("done k=%0d words=%0d", k, hs_count);
  endtask

  task automatic wait_index(input int idx, input int budget);
    int n = 0;
    while (!(bus.out_valid && bus.out_index == 14'(idx)) && n < budget) begin
      tick();
      n++;
    end
    check("reach_index", bus.out_index, idx);
  endtask

  task automatic check_reset_outputs();
    check("rst_word", bus.out_word, 0);
    check("rst_index", bus.out_index, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      done_exp   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (bus.done || done_exp) check("done_pulse", bus.done, done_exp);
      if (prev_stall && bus.out_valid) begin
        check("stall_word", bus.out_word, prev_word);
        check("stall_index", bus.out_index, prev_index);
      end
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got 0x%04h expected no word", bus.out_word);
        end else begin
          mon_e = exp_q.pop_front();
          check("word", bus.out_word, mon_e.word);
          check("index", bus.out_index, mon_e.index);
          check("last", bus.out_last, mon_e.last);
          check("popcount", $countones(bus.out_word), cur_k);
          if (mon_e.index > 0) check("ascending", bus.out_word > last_hs_word, 1);
        end
        last_hs_word = bus.out_word;
      end
      done_exp   = bus.out_valid && bus.out_ready && !bus.abort && bus.out_last;
      prev_stall = bus.out_valid && !bus.out_ready && !bus.abort;
      prev_word  = bus.out_word;
      prev_index = bus.out_index;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.weight = '0;
    bus.abort  = 1'b0;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    start_seq(2);
    check("k2_first_word", bus.out_word, 16'h0003);
    wait_done(2, 200);

    for (int k = 0; k <= 16; k++) begin
      if (k == 7 || k == 9) continue;
      start_seq(k);
      if (k == 0) check("k0_word", bus.out_word, 16'h0000);
      if (k == 16) check("k16_word", bus.out_word, 16'hFFFF);
      if (k == 0 || k == 16) check("single_last", bus.out_last, 1);
      wait_done(k, binom(k) + 10);
    end

    tick();
    bus.weight = 5'd17;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    check("err_pulse", bus.err, 1);
    check("err_valid", bus.out_valid, 0);
    check("err_busy", bus.busy, 0);
    tick();
    check("err_one_cycle", bus.err, 0);
    check("err_still_idle", bus.out_valid, 0);
    $display("reject weight=17 err pulsed");

    ready_rand = 1'b1;
    start_seq(3);
    repeat (20) tick();
    bus.weight = 5'd17;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    check("midstream_no_err", bus.err, 0);
    check("midstream_busy", bus.busy, 1);
    repeat (20) tick();
    bus.weight = 5'd5;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(3, 5000);
    ready_rand = 1'b0;

    start_seq(8);
    wait_index(100, 500);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", bus.done, 0);
      tick();
    end
    $display("abort at index 100");

    start_seq(8);
    wait_index(50, 300);
    rst = 1'b1;
    tick();
    check_reset_outputs();
    exp_q.delete();
    rst = 1'b0;
    $display("reset at index 50");
    start_seq(1);
    check("after_rst_word", bus.out_word, 16'h0001);
    wait_done(1, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
